// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: widths and FSM state codes.
package div_unit_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // A value is negative only when it is treated as signed and its MSB is set.
    function automatic logic is_negative(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: operands and controls in, stall/ready/result out.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_W
);

    logic                  start_i;
    logic                  signed_i;
    logic                  annul_i;
    logic [DATA_W-1:0]     a_i;
    logic [DATA_W-1:0]     b_i;
    logic                  stall_o;
    logic                  ready_o;
    logic [2*DATA_W-1:0]   result_o;

    modport master (
        output start_i, signed_i, annul_i, a_i, b_i,
        input  stall_o, ready_o, result_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, a_i, b_i,
        output stall_o, ready_o, result_o
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Holds the pipeline
// while iterating and presents {HI=remainder, LO=quotient} with a ready pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      resetn,
    div_unit_if.slave bus
);

    div_state_e          state_r;
    logic [CNT_W-1:0]    count_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DATA_W-1:0]   quo_r;
    logic [DATA_W-1:0]   divisor_r;
    logic [DATA_W-1:0]   a_raw_r;
    logic                a_neg_r;
    logic                q_neg_r;
    logic                dz_r;
    logic                ready_r;
    logic [2*DATA_W-1:0] result_r;

    logic [DATA_W:0]     shift_s;
    logic [DATA_W:0]     trial_s;
    logic [DATA_W-1:0]   rem_nxt_s;
    logic [DATA_W-1:0]   quo_nxt_s;
    logic [DATA_W-1:0]   neg_in0_s;
    logic [DATA_W-1:0]   neg_in1_s;
    logic [DATA_W-1:0]   neg0_s;
    logic [DATA_W-1:0]   neg1_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic [DATA_W-1:0]   rem_fix_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic                last_s;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return {DATA_W{1'b0}} - v;
    endfunction

    // One restoring step. Since rem < divisor, the shifted value is below
    // 2*divisor, so bit DATA_W of the difference is set exactly on borrow.
    always_comb begin
        shift_s   = {rem_r, quo_r[DATA_W-1]};
        trial_s   = shift_s - {1'b0, divisor_r};
        rem_nxt_s = {DATA_W{1'b0}};
        quo_nxt_s = {DATA_W{1'b0}};
        if (trial_s[DATA_W] == 1'b0) begin
            rem_nxt_s = trial_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = shift_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b0};
        end
    end

    // The two negators take operand magnitudes in IDLE and fix result signs otherwise.
    always_comb begin
        a_neg_s   = is_negative(bus.a_i[DATA_W-1], bus.signed_i);
        b_neg_s   = is_negative(bus.b_i[DATA_W-1], bus.signed_i);
        neg_in0_s = {DATA_W{1'b0}};
        neg_in1_s = {DATA_W{1'b0}};
        if (state_r == DIV_IDLE) begin
            neg_in0_s = bus.a_i;
            neg_in1_s = bus.b_i;
        end else begin
            neg_in0_s = quo_nxt_s;
            neg_in1_s = rem_nxt_s;
        end
        neg0_s    = negate(neg_in0_s);
        neg1_s    = negate(neg_in1_s);
        quo_fix_s = q_neg_r ? neg0_s : quo_nxt_s;
        rem_fix_s = a_neg_r ? neg1_s : rem_nxt_s;
        last_s    = (count_r == CNT_W'(DATA_W - 1));
    end

    // Control FSM and datapath registers; result is captured on entry to DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= DIV_IDLE;
            count_r   <= {CNT_W{1'b0}};
            rem_r     <= {DATA_W{1'b0}};
            quo_r     <= {DATA_W{1'b0}};
            divisor_r <= {DATA_W{1'b0}};
            a_raw_r   <= {DATA_W{1'b0}};
            a_neg_r   <= 1'b0;
            q_neg_r   <= 1'b0;
            dz_r      <= 1'b0;
            ready_r   <= 1'b0;
            result_r  <= {(2*DATA_W){1'b0}};
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    ready_r <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        state_r   <= DIV_BUSY;
                        count_r   <= {CNT_W{1'b0}};
                        rem_r     <= {DATA_W{1'b0}};
                        quo_r     <= a_neg_s ? neg0_s : bus.a_i;
                        divisor_r <= b_neg_s ? neg1_s : bus.b_i;
                        a_raw_r   <= bus.a_i;
                        a_neg_r   <= a_neg_s;
                        q_neg_r   <= a_neg_s ^ b_neg_s;
                        dz_r      <= (bus.b_i == {DATA_W{1'b0}});
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (bus.annul_i) begin
                        state_r <= DIV_IDLE;
                        ready_r <= 1'b0;
                    end else if (dz_r) begin
                        state_r  <= DIV_DONE;
                        ready_r  <= 1'b1;
                        result_r <= {a_raw_r, {DATA_W{1'b1}}};
                    end else begin
                        rem_r   <= rem_nxt_s;
                        quo_r   <= quo_nxt_s;
                        count_r <= count_r + CNT_W'(1);
                        if (last_s) begin
                            state_r  <= DIV_DONE;
                            ready_r  <= 1'b1;
                            result_r <= {rem_fix_s, quo_fix_s};
                        end else begin
                            state_r <= DIV_BUSY;
                        end
                    end
                end
                DIV_DONE: begin
                    state_r <= DIV_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= DIV_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the accepting IDLE cycle and all of BUSY; it drops in DONE.
    assign bus.stall_o  = ((state_r == DIV_IDLE) & bus.start_i & ~bus.annul_i) |
                          (state_r == DIV_BUSY);
    assign bus.ready_o  = ready_r & ~bus.annul_i;
    assign bus.result_o = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: per-cycle comparison against a
// behavioural timeline model, directed cases and randomized divides.
module tb_div_unit;

    logic clk;
    logic resetn;
    logic chk_en;
    int   n_checks;
    int   n_fail;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result straight from the arithmetic definition of DIV/DIVU.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: 0 = idle, 1 = working (m_left cycles to go), 2 = result cycle.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [63:0] m_pending = 64'd0;
    logic [63:0] m_result  = 64'd0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_phase  <= 0;
            m_left   <= 0;
            m_result <= 64'd0;
        end else if (m_phase == 0) begin
            if (bus.start_i && !bus.annul_i) begin
                m_phase   <= 1;
                m_left    <= (bus.b_i == 32'd0) ? 1 : 32;
                m_pending <= ref_div(bus.a_i, bus.b_i, bus.signed_i);
            end
        end else if (m_phase == 1) begin
            if (bus.annul_i) begin
                m_phase <= 0;
            end else begin
                if (m_left == 1) begin
                    m_phase  <= 2;
                    m_result <= m_pending;
                end
                m_left <= m_left - 1;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", {63'd0, bus.stall_o},
                {63'd0, (m_phase == 0 && bus.start_i && !bus.annul_i) || m_phase == 1});
            chk("ready_o", {63'd0, bus.ready_o}, {63'd0, m_phase == 2 && !bus.annul_i});
            chk("result_o", bus.result_o, m_result);
        end
    end

    // Caller sits at posedge+2; returns at posedge+2 of the ready cycle.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output int lat, output logic [63:0] res);
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = s;
        bus.start_i  = 1'b1;
        lat = -1;
        res = 64'd0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #2;
            if (bus.ready_o) begin
                lat = k;
                res = bus.result_o;
                break;
            end
        end
        if (lat < 0) chk("ready timeout", 64'd0, 64'd1);
    endtask

    // Randomized operation with optional annul while working.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int annul_at);
        bit finished;
        finished = 1'b0;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.signed_i = s;
        bus.start_i  = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #2;
            if (bus.annul_i || m_phase == 0) begin
                bus.annul_i = 1'b0;
                bus.start_i = 1'b0;
                finished = 1'b1;
                break;
            end
            if (k == annul_at && m_phase == 1) bus.annul_i = 1'b1;
        end
        if (!finished) begin
            chk("run_op timeout", 64'd0, 64'd1);
            bus.start_i = 1'b0;
            bus.annul_i = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          lat;
        logic [63:0] res;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        resetn   = 1'b0;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.annul_i  = 1'b0;
        bus.a_i      = 32'd0;
        bus.b_i      = 32'd0;

        // Pin the reference model with hand-computed values.
        chk("model divu 100/7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("model div -7/2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model div 7/-2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), {32'd1, 32'hFFFF_FFFD});
        chk("model div min/-1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
        chk("model div by 0", ref_div(32'd5, 32'd0, 1'b0), {32'd5, 32'hFFFF_FFFF});

        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        chk("reset result", bus.result_o, 64'd0);
        chk("reset ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset stall", {63'd0, bus.stall_o}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #2;

        // 1: DIVU 100/7
        start_and_wait(32'd100, 32'd7, 1'b0, lat, res);
        chk("t1 latency", 64'(lat), 64'd33);
        chk("t1 result", res, {32'd2, 32'd14});
        chk("t1 stall in done", {63'd0, bus.stall_o}, 64'd0);
        @(posedge clk); #2; bus.start_i = 1'b0;

        // 2: signed sign fix-up
        start_and_wait(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
        chk("t2 -7/2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(posedge clk); #2; bus.start_i = 1'b0;
        start_and_wait(32'd7, 32'hFFFF_FFFE, 1'b1, lat, res);
        chk("t2 7/-2", res, {32'd1, 32'hFFFF_FFFD});
        @(posedge clk); #2; bus.start_i = 1'b0;

        // 3: most-negative / -1, signed and unsigned
        start_and_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
        chk("t3 div min/-1", res, {32'd0, 32'h8000_0000});
        @(posedge clk); #2; bus.start_i = 1'b0;
        start_and_wait(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
        chk("t3 divu", res, {32'h8000_0000, 32'd0});
        @(posedge clk); #2; bus.start_i = 1'b0;

        // 4: divide by zero
        start_and_wait(32'd5, 32'd0, 1'b0, lat, res);
        chk("t4 latency", 64'(lat), 64'd2);
        chk("t4 result", res, {32'd5, 32'hFFFF_FFFF});
        @(posedge clk); #2; bus.start_i = 1'b0;

        // 5: annul mid-operation, then a fresh divide
        bus.a_i = 32'd1234; bus.b_i = 32'd5; bus.signed_i = 1'b0; bus.start_i = 1'b1;
        repeat (10) begin @(posedge clk); #2; end
        bus.annul_i = 1'b1;
        chk("t5 ready during annul", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk); #2;
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        chk("t5 stall after annul", {63'd0, bus.stall_o}, 64'd0);
        chk("t5 result held", bus.result_o, {32'd5, 32'hFFFF_FFFF});
        start_and_wait(32'd9, 32'd3, 1'b0, lat, res);
        chk("t5 latency", 64'(lat), 64'd33);
        chk("t5 result", res, {32'd0, 32'd3});
        @(posedge clk); #2; bus.start_i = 1'b0;

        // 6a: reset in the middle of an operation
        bus.a_i = 32'd1000; bus.b_i = 32'd3; bus.signed_i = 1'b0; bus.start_i = 1'b1;
        repeat (20) begin @(posedge clk); #2; end
        resetn = 1'b0; bus.start_i = 1'b0;
        @(posedge clk); #2;
        chk("t6 reset result", bus.result_o, 64'd0);
        chk("t6 reset ready", {63'd0, bus.ready_o}, 64'd0);
        chk("t6 reset stall", {63'd0, bus.stall_o}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #2;

        // 6b: back-to-back divides with start held high
        start_and_wait(32'd1000, 32'd3, 1'b0, lat, res);
        chk("t6 first latency", 64'(lat), 64'd33);
        chk("t6 first result", res, {32'd1, 32'd333});
        @(posedge clk); #2;
        chk("t6 second accept stall", {63'd0, bus.stall_o}, 64'd1);
        start_and_wait(32'hFFFF_FF9C, 32'd7, 1'b1, lat, res);
        chk("t6 second latency", 64'(lat), 64'd33);
        chk("t6 second result", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        @(posedge clk); #2; bus.start_i = 1'b0;

        // Randomized operations, checked cycle by cycle against the model.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = ra | 32'h0000_0001;
                4: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 34)) : 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
